// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// Module  : branch_redirect_ctrl
// Brief   : EX-stage branch resolution, PC redirect/flush sequencing, 2-bit BHT
//           (present only when BRANCH_PREDICT_EN is defined) and perf counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             br_out,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  logic               redirect_q;
  logic               flush_if_id_q;
  logic               flush_id_ex_q;
  logic [31:0]        redirect_pc_q;
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mispred_cnt_q;

  logic               resolve_d;
  logic               taken_d;
  logic               pred_d;
  logic               mispred_d;
  logic [31:0]        corr_pc_d;
  logic               unused_ok;

  // Wrong-path instructions sit in EX during REDIR/DRAIN, so only RUN resolves.
  assign resolve_d = (state_q == RUN) && ex_valid && !stall && (ex_is_branch || ex_is_jump);
  assign taken_d   = ex_is_jump | br_out;
  assign mispred_d = taken_d != pred_d;
  assign corr_pc_d = taken_d ? ex_target : (ex_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      redirect_q    <= 1'b0;
      flush_if_id_q <= 1'b0;
      flush_id_ex_q <= 1'b0;
      redirect_pc_q <= 32'd0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (resolve_d) begin
            redirect_pc_q <= corr_pc_d;
            if (branch_cnt_q != {CNT_W{1'b1}}) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispred_d) begin
              if (mispred_cnt_q != {CNT_W{1'b1}}) mispred_cnt_q <= mispred_cnt_q + 1'b1;
              state_q       <= REDIR;
              redirect_q    <= 1'b1;
              flush_if_id_q <= 1'b1;
              flush_id_ex_q <= 1'b1;
            end
          end
        end
        REDIR: begin
          if (!stall) begin
            state_q       <= DRAIN;
            redirect_q    <= 1'b0;
            flush_id_ex_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!stall) begin
            state_q       <= RUN;
            flush_if_id_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= RUN;
          redirect_q    <= 1'b0;
          flush_if_id_q <= 1'b0;
          flush_id_ex_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_PREDICT_EN
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       bht_q [ENTRIES];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = ex_pc[IDX_W+1:2];
  assign rd_idx = if_pc[IDX_W+1:2];
  assign pred_d = ex_pred_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (resolve_d && ex_is_branch && !ex_is_jump) begin
      if (br_out && (bht_q[wr_idx] != 2'b11))
        bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
      else if (!br_out && (bht_q[wr_idx] != 2'b00))
        bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
    end
  end

  // Combinational read returns the pre-update value on a same-index write.
  assign if_pred_taken = bht_q[rd_idx][1];
  assign unused_ok     = ^{if_pc[31:IDX_W+2], if_pc[1:0]};
`else
  // Static not-taken: the carried prediction is meaningless without a table.
  assign pred_d        = 1'b0;
  assign if_pred_taken = 1'b0;
  assign unused_ok     = ^{if_pc, ex_pred_taken};
`endif

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush_if_id = flush_if_id_q;
  assign flush_id_ex = flush_id_ex_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire
